// File: rtl/sram_bist_master.sv
// -----------------------------------------------------------------------------
// sram_bist_master
//   Bus-side built-in self test for sram_controller. On a start edge it writes
//   an address-derived pattern over a window of BaseRAM, reads the window back,
//   compares each word and reports the number of mismatches and the address of
//   the first one.
//
//   Pattern : P(a) = {~a[11:0], a[19:0]} ^ SEED
//   Window  : a = (ADDR_BASE + off) mod 2^20, off = 0 .. DEPTH-1
//
// Ports
//   clock_btn       in   1   clock
//   reset_btn       in   1   asynchronous reset, active-high
//   start           in   1   level; a rising edge starts one test pass
//   inject_err      in   1   invert bit0 of the word written at ADDR_BASE
//   read_op         out  1   read request
//   write_op        out  1   write request
//   bus_addr        out  20  word address
//   bus_data_write  out  32  write data
//   byte_mask       out  4   byte enables, always 4'b1111
//   bus_data_read   in   32  read data, valid in the accepting cycle
//   bus_stall       in   1   request not accepted this cycle; outputs hold
//   busy            out  1   pass in progress (WRITE/READ)
//   done            out  1   pass finished; held until next start or reset
//   pass            out  1   pass finished with no mismatches
//   err_count       out  16  mismatch count, saturating
//   fail_addr       out  20  address of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module sram_bist_master #(
  parameter logic [19:0] ADDR_BASE = 20'h00000,
  parameter logic [20:0] DEPTH     = 21'd1024,
  parameter logic [31:0] SEED      = 32'h5A5A0000
) (
  input  logic        clock_btn,
  input  logic        reset_btn,
  input  logic        start,
  input  logic        inject_err,
  output logic        read_op,
  output logic        write_op,
  output logic [19:0] bus_addr,
  output logic [31:0] bus_data_write,
  output logic [3:0]  byte_mask,
  input  logic [31:0] bus_data_read,
  input  logic        bus_stall,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [19:0] fail_addr
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t      r_state,    w_state_next;
  logic        r_start_s;                  // start sampled into the clock domain
  logic        r_start_q;                  // previous sample, for edge detection
  logic [20:0] r_off,      w_off_next;     // 21 bits so DEPTH = 2^20 terminates
  logic [19:0] r_addr,     w_addr_next;
  logic [31:0] r_wdata,    w_wdata_next;
  logic        r_read_op,  w_read_op_next;
  logic        r_write_op, w_write_op_next;
  logic        r_busy,     w_busy_next;
  logic        r_done,     w_done_next;
  logic        r_pass,     w_pass_next;
  logic [15:0] r_err,      w_err_next;
  logic [19:0] r_fail,     w_fail_next;

  logic        w_start_edge;
  logic        w_last;
  logic        w_mismatch;
  logic [19:0] w_addr_inc;

  function automatic logic [31:0] f_pattern(input logic [19:0] a);
    return {~a[11:0], a} ^ SEED;
  endfunction

  assign w_start_edge = r_start_s & ~r_start_q;
  assign w_last       = (r_off == DEPTH - 21'd1);
  assign w_addr_inc   = r_addr + 20'd1;       // 20-bit add wraps FFFFF -> 00000
  assign w_mismatch   = (bus_data_read != f_pattern(r_addr));

  // NOTE: every next-value signal takes its hold value first, so no path
  // through the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next    = r_state;
    w_off_next      = r_off;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    w_read_op_next  = r_read_op;
    w_write_op_next = r_write_op;
    w_busy_next     = r_busy;
    w_done_next     = r_done;
    w_pass_next     = r_pass;
    w_err_next      = r_err;
    w_fail_next     = r_fail;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_edge) begin
          w_state_next    = S_WRITE;
          w_off_next      = 21'd0;
          w_addr_next     = ADDR_BASE;
          // The only write to ADDR_BASE is the first one, so inject here.
          w_wdata_next    = f_pattern(ADDR_BASE) ^ {31'd0, inject_err};
          w_write_op_next = 1'b1;
          w_read_op_next  = 1'b0;
          w_busy_next     = 1'b1;
          w_done_next     = 1'b0;
          w_pass_next     = 1'b0;
          w_err_next      = 16'd0;
          w_fail_next     = 20'd0;
        end
      end

      S_WRITE: begin
        if (!bus_stall) begin
          if (w_last) begin
            w_state_next    = S_READ;
            w_off_next      = 21'd0;
            w_addr_next     = ADDR_BASE;
            w_write_op_next = 1'b0;
            w_read_op_next  = 1'b1;
          end else begin
            w_off_next   = r_off + 21'd1;
            w_addr_next  = w_addr_inc;
            w_wdata_next = f_pattern(w_addr_inc);
          end
        end
      end

      S_READ: begin
        if (!bus_stall) begin
          if (w_mismatch) begin
            if (r_err != 16'hFFFF) w_err_next = r_err + 16'd1;
            if (r_err == 16'd0)    w_fail_next = r_addr;
          end
          if (w_last) begin
            w_state_next   = S_DONE;
            w_read_op_next = 1'b0;
            w_busy_next    = 1'b0;
            w_done_next    = 1'b1;
            // Include the word being compared right now in the verdict.
            w_pass_next    = (r_err == 16'd0) && !w_mismatch;
          end else begin
            w_off_next  = r_off + 21'd1;
            w_addr_next = w_addr_inc;
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock_btn or posedge reset_btn) begin
    if (reset_btn) begin
      r_state    <= S_IDLE;
      r_start_s  <= 1'b0;
      r_start_q  <= 1'b0;
      r_off      <= 21'd0;
      r_addr     <= ADDR_BASE;
      r_wdata    <= 32'd0;
      r_read_op  <= 1'b0;
      r_write_op <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= 16'd0;
      r_fail     <= 20'd0;
    end else begin
      r_state    <= w_state_next;
      r_start_s  <= start;
      r_start_q  <= r_start_s;
      r_off      <= w_off_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
      r_read_op  <= w_read_op_next;
      r_write_op <= w_write_op_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_pass     <= w_pass_next;
      r_err      <= w_err_next;
      r_fail     <= w_fail_next;
    end
  end

  assign read_op        = r_read_op;
  assign write_op       = r_write_op;
  assign bus_addr       = r_addr;
  assign bus_data_write = r_wdata;
  assign byte_mask      = 4'b1111;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign fail_addr      = r_fail;

endmodule

// File: tb/tb_sram_bist_master.sv
// -----------------------------------------------------------------------------
// tb_sram_bist_master
//   Drives sram_bist_master against a behavioural SRAM/bus model with random
//   stalls and optional read corruption. Expected writes, reads and final
//   results are queued when a pass is launched; a monitor pops and compares
//   them as the DUT presents accepted requests and its done result.
//   The window (FFFFA..00005) wraps through address 0.
// -----------------------------------------------------------------------------
module tb_sram_bist_master;

  localparam logic [19:0] BASE = 20'hFFFFA;
  localparam int          D    = 12;
  localparam logic [31:0] SEED = 32'h5A5A0000;
  localparam logic [31:0] FLIP = 32'h8000_0000;

  logic        clock_btn = 1'b0;
  logic        reset_btn;
  logic        start;
  logic        inject_err;
  logic        read_op, write_op;
  logic [19:0] bus_addr;
  logic [31:0] bus_data_write;
  logic [3:0]  byte_mask;
  logic [31:0] bus_data_read = 32'd0;
  logic        bus_stall     = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [19:0] fail_addr;

  int errors = 0;
  int checks = 0;

  always #5 clock_btn = ~clock_btn;

  sram_bist_master #(
    .ADDR_BASE (BASE),
    .DEPTH     (21'(D)),
    .SEED      (SEED)
  ) dut (
    .clock_btn      (clock_btn),
    .reset_btn      (reset_btn),
    .start          (start),
    .inject_err     (inject_err),
    .read_op        (read_op),
    .write_op       (write_op),
    .bus_addr       (bus_addr),
    .bus_data_write (bus_data_write),
    .byte_mask      (byte_mask),
    .bus_data_read  (bus_data_read),
    .bus_stall      (bus_stall),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .fail_addr      (fail_addr)
  );

  typedef struct {logic [19:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic [15:0] n; logic [19:0] fa; logic p;} res_t;

  wr_t         exp_wr[$];
  logic [19:0] exp_rd[$];
  res_t        exp_res[$];

  logic [31:0] mem [16];          // window addresses map to distinct low nibbles
  bit [D-1:0]  corrupt = '0;      // offsets whose read data the model damages
  int          stall_pct = 0;
  int          wr_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: word address for window offset o, with 2^20 wrap.
  function automatic logic [19:0] addr_of(input int o);
    int s;
    s = (int'(BASE) + o) % (1 << 20);
    return s[19:0];
  endfunction

  // Reference pattern: upper 12 bits hold the complement of a[11:0].
  function automatic logic [31:0] pat(input logic [19:0] a);
    logic [11:0] lo;
    lo = 12'hFFF - a[11:0];
    return (({20'd0, lo} << 20) + {12'd0, a}) ^ SEED;
  endfunction

  // Bus/SRAM model: stall and read data are set away from the sampling edge.
  always @(negedge clock_btn) begin
    logic [19:0] o;
    bus_stall = (int'($urandom_range(99)) < stall_pct);
    o = bus_addr - BASE;
    bus_data_read = mem[bus_addr[3:0]] ^
                    ((o < 20'(D) && corrupt[o[3:0]]) ? FLIP : 32'd0);
  end

  // Monitor: what it sees here is accepted at the following rising edge.
  logic        held = 1'b0;
  logic [53:0] snap;
  bit          done_seen = 1'b0;

  always @(negedge clock_btn) begin
    #1;
    if (reset_btn) begin
      held      = 1'b0;
      done_seen = 1'b0;
    end else begin
      if (held)
        check("stall_hold", 64'(snap), 64'({read_op, write_op, bus_addr, bus_data_write}));
      if (read_op || write_op)
        check("rw_exclusive", 64'(read_op & write_op), 64'd0);

      if (write_op && !bus_stall) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h", bus_addr);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", 64'(bus_addr), 64'(e.a));
          check("wr_data", 64'(bus_data_write), 64'(e.d));
          check("byte_mask", 64'(byte_mask), 64'hF);
        end
        mem[bus_addr[3:0]] = bus_data_write;
        wr_seen++;
      end

      if (read_op && !bus_stall) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: addr %0h", bus_addr);
        end else begin
          logic [19:0] ea;
          ea = exp_rd.pop_front();
          check("rd_addr", 64'(bus_addr), 64'(ea));
        end
      end

      if (done && !done_seen) begin
        done_seen = 1'b1;
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: err_count %0h", err_count);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          check("err_count", 64'(err_count), 64'(r.n));
          check("fail_addr", 64'(fail_addr), 64'(r.fa));
          check("pass", 64'(pass), 64'(r.p));
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
      if (!done) done_seen = 1'b0;

      held = (read_op || write_op) && bus_stall;
      snap = {read_op, write_op, bus_addr, bus_data_write};
    end
  end

  // Queue everything one pass must produce.
  task automatic push_expect(input bit inj, input bit [D-1:0] cor);
    res_t r;
    r.n  = 16'd0;
    r.fa = 20'd0;
    for (int o = 0; o < D; o++) begin
      wr_t w;
      w.a = addr_of(o);
      w.d = pat(w.a) ^ ((inj && o == 0) ? 32'd1 : 32'd0);
      exp_wr.push_back(w);
      exp_rd.push_back(w.a);
      if (cor[o] || (inj && o == 0)) begin
        if (r.n == 16'd0) r.fa = w.a;
        r.n = r.n + 16'd1;
      end
    end
    r.p = (r.n == 16'd0);
    exp_res.push_back(r);
  endtask

  task automatic run_pass(input int pct, input bit inj, input bit [D-1:0] cor, input bit chk_lat);
    int  cyc;
    bit  seen_busy;
    stall_pct = pct;
    corrupt   = cor;
    @(negedge clock_btn);
    inject_err = inj;
    push_expect(inj, cor);
    start = 1'b1;
    cyc = 0;
    seen_busy = 1'b0;
    while (cyc < 400) begin
      @(posedge clock_btn);
      cyc++;
      #1;
      if (busy) seen_busy = 1'b1;
      if (seen_busy && done) break;
    end
    if (!(seen_busy && done)) begin
      checks++; errors++;
      $display("FAIL done_timeout: busy_seen %0d done %0d", seen_busy, done);
    end else if (chk_lat) begin
      check("latency", 64'(cyc), 64'(2 * D + 2));
    end
    // start still held high: no new edge, so no restart.
    repeat (4) @(negedge clock_btn);
    #2;
    check("held_start_no_restart", 64'({done, busy}), 64'b10);
    @(negedge clock_btn);
    start      = 1'b0;
    inject_err = 1'b0;
    check("queues_drained", 64'(exp_wr.size() + exp_rd.size() + exp_res.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] rnd;
    reset_btn  = 1'b1;
    start      = 1'b0;
    inject_err = 1'b0;
    repeat (3) @(negedge clock_btn);
    #2;
    check("rst_req", 64'({read_op, write_op, busy, done, pass}), 64'd0);
    check("rst_addr", 64'(bus_addr), 64'(BASE));
    check("rst_wdata", 64'(bus_data_write), 64'd0);
    check("rst_results", 64'({err_count, fail_addr}), 64'd0);
    check("rst_mask", 64'(byte_mask), 64'hF);
    @(negedge clock_btn);
    reset_btn = 1'b0;

    // Clean pass without stalls; exact latency.
    run_pass(0, 1'b0, '0, 1'b1);
    // P(0) = {12'hFFF, 20'h00000} ^ 32'h5A5A0000
    check("mem0_pattern", 64'(mem[0]), 64'hA5AA0000);

    // Heavy stalling.
    run_pass(50, 1'b0, '0, 1'b0);

    // Self-check injection at ADDR_BASE.
    run_pass(0, 1'b1, '0, 1'b1);

    // Random stalls, injection and read corruption (incl. last word).
    for (int i = 0; i < 6; i++) begin
      rnd = $urandom;
      if (i == 0) rnd = 32'(1) << (D - 1);
      run_pass(int'($urandom_range(60)), 1'($urandom_range(1)), rnd[D-1:0], 1'b0);
    end

    // Reset in the middle of the write phase.
    stall_pct = 0;
    corrupt   = '0;
    @(negedge clock_btn);
    push_expect(1'b0, '0);
    wr_seen = 0;
    start   = 1'b1;
    for (int c = 0; c < 100 && wr_seen < 4; c++) @(negedge clock_btn);
    check("mid_write_reached", 64'(wr_seen >= 4 && write_op), 64'd1);
    #3;
    reset_btn = 1'b1;
    #1;
    check("abort_req", 64'({read_op, write_op}), 64'd0);
    check("abort_status", 64'({busy, done, pass}), 64'd0);
    check("abort_results", 64'({err_count, fail_addr}), 64'd0);
    start = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    exp_res.delete();
    @(negedge clock_btn);
    @(negedge clock_btn);
    reset_btn = 1'b0;
    run_pass(30, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
